// File: rtl/stats_counter_ram_pkg.sv
// Shared definitions for the statistics counter RAM block.
// STATS_COUNTER_RAM_SAT_EN selects a saturating counter add instead of a wrapping one.
package stats_counter_ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic WORD_LO   = 1'b0;
    localparam logic WORD_HI   = 1'b1;
    localparam int   COUNTER_W = 64;

    function automatic logic [COUNTER_W-1:0] counter_add(
        input logic [COUNTER_W-1:0] base,
        input logic [COUNTER_W-1:0] inc
    );
`ifdef STATS_COUNTER_RAM_SAT_EN
        logic [COUNTER_W:0] full;
        full = {1'b0, base} + {1'b0, inc};
        counter_add = full[COUNTER_W] ? {COUNTER_W{1'b1}} : full[COUNTER_W-1:0];
`else
        counter_add = base + inc;
`endif
    endfunction

endpackage

// File: rtl/stats_counter_ram_mem.sv
// Simple dual-port counter RAM: one write port, one registered read port.
// A read colliding with a write to the same address returns the old contents.
module stats_counter_ram_mem
    import stats_counter_ram_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = COUNTER_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/stats_counter_ram.sv
// RAM-backed bank of 64-bit statistics counters fed by an increment stream, read as 32-bit words.
// Build option STATS_COUNTER_RAM_SAT_EN makes counters saturate instead of wrap.
module stats_counter_ram
    import stats_counter_ram_pkg::*;
#(
    parameter int STAT_INC_WIDTH   = 24,
    parameter int STAT_ID_WIDTH    = 5,
    parameter int STAT_COUNT_WIDTH = 64,
    parameter int REG_ADDR_WIDTH   = STAT_ID_WIDTH + 3,
    parameter int REG_DATA_WIDTH   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STAT_INC_WIDTH-1:0] s_axis_stat_tdata,
    input  logic [STAT_ID_WIDTH-1:0]  s_axis_stat_tid,
    input  logic                      s_axis_stat_tvalid,
    output logic                      s_axis_stat_tready,
    input  logic [REG_ADDR_WIDTH-1:0] reg_rd_addr,
    input  logic                      reg_rd_en,
    output logic [REG_DATA_WIDTH-1:0] reg_rd_data,
    output logic                      reg_rd_wait,
    output logic                      reg_rd_ack
);

    localparam int IW = STAT_ID_WIDTH;

    state_t                      state_q, state_d;
    logic [IW-1:0]               init_ptr;
    logic                        rd_pending;
    logic [REG_ADDR_WIDTH-1:0]   pend_addr;
    logic [REG_ADDR_WIDTH-1:0]   rd_addr_sel;
    logic                        rd_grant, upd_fire;
    logic [IW-1:0]               raddr;
    logic [COUNTER_W-1:0]        ram_rdata, base, sum;
    logic                        ram_we;
    logic [IW-1:0]               ram_waddr;
    logic [COUNTER_W-1:0]        ram_wdata;

    logic                        s1_upd, s1_rd, s1_word;
    logic [IW-1:0]               s1_idx;
    logic [STAT_INC_WIDTH-1:0]   s1_inc;
    logic                        fwd_vld;
    logic [IW-1:0]               fwd_idx;
    logic [COUNTER_W-1:0]        fwd_sum;
    logic                        snap_valid;
    logic [IW-1:0]               snap_idx;
    logic [REG_DATA_WIDTH-1:0]   snap_hi;
    logic                        addr_unused;

    assign addr_unused = &{1'b0, reg_rd_addr[1:0], pend_addr[1:0]};

    // Register reads own the single RAM read port whenever one is waiting.
    assign rd_addr_sel        = rd_pending ? pend_addr : reg_rd_addr;
    assign rd_grant           = (state_q == ST_RUN) && (reg_rd_en || rd_pending);
    assign s_axis_stat_tready = (state_q == ST_RUN) && !(reg_rd_en || rd_pending);
    assign upd_fire           = s_axis_stat_tvalid && s_axis_stat_tready;
    assign raddr              = rd_grant ? rd_addr_sel[IW+2:3] : s_axis_stat_tid;
    assign reg_rd_wait        = rd_pending;

    // The RAM has not yet seen last cycle's write, so take that sum directly.
    assign base = (fwd_vld && fwd_idx == s1_idx) ? fwd_sum : ram_rdata;
    assign sum  = counter_add(base, {{(COUNTER_W-STAT_INC_WIDTH){1'b0}}, s1_inc});

    assign ram_we    = !rst && ((state_q == ST_INIT) || s1_upd);
    assign ram_waddr = (state_q == ST_INIT) ? init_ptr : s1_idx;
    assign ram_wdata = (state_q == ST_INIT) ? '0 : sum;

    stats_counter_ram_mem #(.ADDR_W(IW), .DATA_W(COUNTER_W)) u_mem (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && init_ptr == {IW{1'b1}}) state_d = ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_INIT;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_ptr    <= '0;
            rd_pending  <= 1'b0;
            pend_addr   <= '0;
            s1_upd      <= 1'b0;
            s1_rd       <= 1'b0;
            fwd_vld     <= 1'b0;
            snap_valid  <= 1'b0;
            reg_rd_ack  <= 1'b0;
            reg_rd_data <= '0;
        end else begin
            if (state_q == ST_INIT) init_ptr <= init_ptr + 1'b1;
            if (state_q == ST_INIT && reg_rd_en) begin
                rd_pending <= 1'b1;
                pend_addr  <= reg_rd_addr;
            end else if (rd_grant) begin
                rd_pending <= 1'b0;
            end
            s1_upd     <= upd_fire;
            s1_rd      <= rd_grant;
            fwd_vld    <= s1_upd;
            reg_rd_ack <= s1_rd;
            if (s1_rd) begin
                if (s1_word == WORD_LO) begin
                    reg_rd_data <= base[31:0];
                    snap_valid  <= 1'b1;
                end else if (snap_valid && snap_idx == s1_idx) begin
                    reg_rd_data <= snap_hi;
                    snap_valid  <= 1'b0;
                end else begin
                    reg_rd_data <= base[63:32];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        s1_idx  <= raddr;
        s1_inc  <= s_axis_stat_tdata;
        s1_word <= rd_addr_sel[2];
        fwd_idx <= s1_idx;
        fwd_sum <= sum;
        if (s1_rd && s1_word == WORD_LO) begin
            snap_hi  <= base[63:32];
            snap_idx <= s1_idx;
        end
    end

endmodule
